// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Word-addressed backing memory that answers a VALID/READY memory port, one
// 32-bit beat per handshake. A request is sampled in IDLE and acknowledged
// with a single-cycle READY after a programmable latency. A beat that directly
// follows the previous beat (address +4, same direction, no idle gap) uses the
// shorter NEXT_LAT. This models burst line fills and write-backs.
//
// Parameters
//   ADDR_W       byte-address width
//   MEM_WORDS_W  log2 of the word count; word index = ADDR[2 +: MEM_WORDS_W]
//   FIRST_LAT    request-sample-to-READY cycles, non-sequential beat (>= 1)
//   NEXT_LAT     request-sample-to-READY cycles, sequential beat (>= 1)
//   INIT_FILE    preload image name; no preload is performed
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_mem_ADDR          byte address (bits [1:0] ignored, upper bits alias)
//   i_mem_WDATA         write data
//   i_mem_BMASK         byte enables for writes
//   i_mem_WREN          1 = write, 0 = read
//   i_mem_VALID         request valid, held by the initiator until READY
//   o_mem_READY         one-cycle beat acknowledge
//   o_mem_RDATA         read data, valid in the READY cycle, held otherwise
//
// Optional feature (macro MEM_RESP_STATS_EN)
//   o_stat_rd_beats     read beats acknowledged (wrapping)
//   o_stat_wr_beats     write beats acknowledged (wrapping)
//   o_stat_wait_cycles  cycles spent in WAIT (wrapping)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int    ADDR_W      = 18,
    parameter int    MEM_WORDS_W = 16,
    parameter int    FIRST_LAT   = 4,
    parameter int    NEXT_LAT    = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_mem_ADDR,
    input  logic [31:0]       i_mem_WDATA,
    input  logic [3:0]        i_mem_BMASK,
    input  logic              i_mem_WREN,
    input  logic              i_mem_VALID,
    output logic              o_mem_READY,
    output logic [31:0]       o_mem_RDATA
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]       o_stat_rd_beats,
    output logic [31:0]       o_stat_wr_beats,
    output logic [31:0]       o_stat_wait_cycles
`endif
);

    localparam int DEPTH   = 1 << MEM_WORDS_W;
    localparam int MAX_LAT = (FIRST_LAT > NEXT_LAT) ? FIRST_LAT : NEXT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    if (FIRST_LAT < 1 || NEXT_LAT < 1) begin : g_bad_lat
        $error("mem_responder: FIRST_LAT and NEXT_LAT must both be >= 1");
    end
    if (ADDR_W < MEM_WORDS_W + 2) begin : g_bad_addr
        $error("mem_responder: ADDR_W must be at least MEM_WORDS_W + 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                seq_q, seq_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          bmask_q, bmask_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   prev_addr_q;
    logic                prev_wren_q;
    logic [31:0]         rdata_q;
    logic                is_seq;
    int unsigned         lat;

    logic [31:0] mem [DEPTH];

    // Next-state logic. A sampled request commits: once out of IDLE the beat
    // runs to ACK on the latched copy regardless of what the inputs do.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        bmask_d = bmask_q;
        wren_d  = wren_q;

        // The +4 wraps modulo 2^ADDR_W because the sum is ADDR_W bits wide.
        is_seq = seq_q
              && (i_mem_ADDR == prev_addr_q + ADDR_W'(4))
              && (i_mem_WREN == prev_wren_q);
        lat    = is_seq ? NEXT_LAT : FIRST_LAT;

        unique case (state_q)
            S_IDLE: begin
                if (i_mem_VALID) begin
                    addr_d  = i_mem_ADDR;
                    wdata_d = i_mem_WDATA;
                    bmask_d = i_mem_BMASK;
                    wren_d  = i_mem_WREN;
                    if (lat == 1) begin
                        state_d = S_ACK;
                    end else begin
                        // WAIT runs cnt+1 cycles, putting READY at sample + lat.
                        cnt_d   = CNT_W'(lat - 2);
                        state_d = S_WAIT;
                    end
                end else begin
                    // An idle gap breaks the burst.
                    seq_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                seq_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            seq_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bmask_q     <= '0;
            wren_q      <= 1'b0;
            prev_addr_q <= '0;
            prev_wren_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bmask_q <= bmask_d;
            wren_q  <= wren_d;
            if (state_q == S_ACK) begin
                prev_addr_q <= addr_q;
                prev_wren_q <= wren_q;
            end
        end
    end

    // Read data is captured on the edge that enters ACK. addr_d/wren_d already
    // reflect the request when a NEXT_LAT=1 beat goes straight from IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
        end else if (state_d == S_ACK && state_q != S_ACK && !wren_d) begin
            rdata_q <= mem[addr_d[2 +: MEM_WORDS_W]];
        end
    end

    // Write commits on the edge that leaves ACK; a reset before that edge
    // drops the beat and leaves memory untouched.
    // NOTE: the storage array has no reset; clearing it would turn a RAM into
    // a huge bank of flops, and its contents are defined by writes.
    always_ff @(posedge i_clk) begin
        if (state_q == S_ACK && wren_q) begin
            for (int b = 0; b < 4; b++) begin
                if (bmask_q[b]) begin
                    mem[addr_q[2 +: MEM_WORDS_W]][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign o_mem_READY = (state_q == S_ACK);
    assign o_mem_RDATA = rdata_q;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] stat_rd_q, stat_wr_q, stat_wait_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_rd_q   <= '0;
            stat_wr_q   <= '0;
            stat_wait_q <= '0;
        end else begin
            if (state_q == S_ACK && !wren_q) stat_rd_q   <= stat_rd_q + 32'd1;
            if (state_q == S_ACK &&  wren_q) stat_wr_q   <= stat_wr_q + 32'd1;
            if (state_q == S_WAIT)           stat_wait_q <= stat_wait_q + 32'd1;
        end
    end

    assign o_stat_rd_beats    = stat_rd_q;
    assign o_stat_wr_beats    = stat_wr_q;
    assign o_stat_wait_cycles = stat_wait_q;
`endif

    // The initiator must hold a committed request stable until READY.
    a_req_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state_q == S_WAIT) |->
            (i_mem_VALID && i_mem_ADDR == addr_q && i_mem_WDATA == wdata_q))
        else $warning("mem_responder: request changed or dropped while waiting");

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder. A behavioural model holds a word
// array, the burst (sequential) state and the statistics totals, and derives
// the expected latency, read data and counter values for every beat.
// Build with MEM_RESP_STATS_EN defined to also check the statistics outputs.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int ADDR_W      = 18;
    localparam int MEM_WORDS_W = 10;
    localparam int FIRST_LAT   = 4;
    localparam int NEXT_LAT    = 1;
    localparam int DEPTH       = 1 << MEM_WORDS_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic [3:0]        mem_bmask = '0;
    logic              mem_wren = 1'b0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
`ifdef MEM_RESP_STATS_EN
    logic [31:0]       stat_rd, stat_wr, stat_wait;
`endif

    mem_responder #(
        .ADDR_W      (ADDR_W),
        .MEM_WORDS_W (MEM_WORDS_W),
        .FIRST_LAT   (FIRST_LAT),
        .NEXT_LAT    (NEXT_LAT),
        .INIT_FILE   ("")
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mem_ADDR  (mem_addr),
        .i_mem_WDATA (mem_wdata),
        .i_mem_BMASK (mem_bmask),
        .i_mem_WREN  (mem_wren),
        .i_mem_VALID (mem_valid),
        .o_mem_READY (mem_ready),
        .o_mem_RDATA (mem_rdata)
`ifdef MEM_RESP_STATS_EN
        ,
        .o_stat_rd_beats    (stat_rd),
        .o_stat_wr_beats    (stat_wr),
        .o_stat_wait_cycles (stat_wait)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]       mem_m [DEPTH];
    bit                seq_m       = 1'b0;   // previous beat can be continued
    logic [ADDR_W-1:0] prev_addr_m = '0;
    bit                prev_wren_m = 1'b0;
    bit                in_ack      = 1'b0;   // DUT sits in its READY cycle now
    logic [31:0]       last_rdata_m = '0;
    int unsigned       rd_m = 0, wr_m = 0, wait_m = 0;

    function automatic int word_idx(input logic [ADDR_W-1:0] a);
        return int'(a >> 2) % DEPTH;
    endfunction

    task automatic check_stats(input string tag);
`ifdef MEM_RESP_STATS_EN
        check({tag, "_st_rd"},   stat_rd,   32'(rd_m));
        check({tag, "_st_wr"},   stat_wr,   32'(wr_m));
        check({tag, "_st_wait"}, stat_wait, 32'(wait_m));
`endif
    endtask

    // One handshake. Called at #1 after a posedge; returns at #1 after the
    // posedge that raised READY, with VALID already dropped.
    task automatic beat(input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                        input logic [3:0] bmask, input logic wren, input string tag,
                        output logic [31:0] rdata);
        logic [ADDR_W-1:0] nxt;
        int  exp_l, exp_n, n, idx;
        bit  seen;
        nxt   = prev_addr_m + ADDR_W'(4);
        exp_l = (seq_m && addr == nxt && wren == prev_wren_m) ? NEXT_LAT : FIRST_LAT;
        // If the previous beat is still in its READY cycle, the next edge only
        // returns the DUT to idle and does not sample this request.
        exp_n = exp_l + (in_ack ? 1 : 0);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_bmask = bmask;
        mem_wren  = wren;
        mem_valid = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < FIRST_LAT + 4 && !seen; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_ready) seen = 1'b1;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
        idx   = word_idx(addr);
        rdata = mem_rdata;
        if (wren) begin
            check({tag, "_wr_rdata_hold"}, mem_rdata, last_rdata_m);
            for (int b = 0; b < 4; b++)
                if (bmask[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
            wr_m++;
        end else begin
            check({tag, "_rdata"}, mem_rdata, mem_m[idx]);
            last_rdata_m = mem_m[idx];
            rd_m++;
        end
        wait_m     += exp_l - 1;
        mem_valid   = 1'b0;
        seq_m       = 1'b1;
        prev_addr_m = addr;
        prev_wren_m = wren;
        in_ack      = 1'b1;
    endtask

    // Idle gap with VALID low; long enough to include one idle sample edge,
    // which ends any burst.
    task automatic idle(input int n);
        int cyc;
        cyc = (in_ack && n < 2) ? 2 : n;
        mem_valid = 1'b0;
        for (int k = 0; k < cyc; k++) begin
            @(posedge clk);
            #1;
            check("idle_ready", {31'b0, mem_ready}, 32'd0);
        end
        check("idle_rdata_hold", mem_rdata, last_rdata_m);
        check_stats("idle");
        seq_m  = 1'b0;
        in_ack = 1'b0;
    endtask

    initial begin
        logic [31:0]       rd;
        logic [ADDR_W-1:0] a;
        logic              w;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_stats("rst");

        // ---- fill the whole array with one sequential write burst ----
        for (int i = 0; i < DEPTH; i++)
            beat(ADDR_W'(i * 4), $urandom, 4'hF, 1'b1, "fill", rd);
        idle(2);
        beat(18'h00040, 32'hDEADBEEF, 4'hF, 1'b1, "pre10", rd);
        beat(18'h00044, 32'h0BADF00D, 4'hF, 1'b1, "pre11", rd);
        idle(2);
        beat(18'h00080, 32'hAAAAAAAA, 4'hF, 1'b1, "pre20", rd);
        idle(2);

        // ---- scenario 1: single read, FIRST_LAT ----
        beat(18'h00040, 32'h0, 4'h0, 1'b0, "s1", rd);
        check("s1_value", rd, 32'hDEADBEEF);
        idle(2);

        // ---- scenario 4: write burst then immediate read burst ----
        for (int i = 0; i < 16; i++)
            beat(ADDR_W'(18'h00200 + i * 4), $urandom, 4'(i + 1), 1'b1, "s4w", rd);
        for (int i = 16; i < 24; i++)
            beat(ADDR_W'(18'h00200 + i * 4), 32'h0, 4'h0, 1'b0, "s4r", rd);
        idle(1);

        // ---- sequential detection across the top of the address space ----
        beat(18'h3FFFC, 32'h0, 4'h0, 1'b0, "wrap0", rd);
        beat(18'h00000, 32'h0, 4'h0, 1'b0, "wrap1", rd);
        idle(2);

        // ---- word-index aliasing ----
        beat(18'h20200, 32'hC0FFEE11, 4'hF, 1'b1, "alias_w", rd);
        idle(2);
        beat(18'h00200, 32'h0, 4'h0, 1'b0, "alias_r", rd);
        check("alias_value", rd, 32'hC0FFEE11);
        idle(2);

        // ---- scenario 5: reset while a write is waiting ----
        mem_addr  = 18'h000C0;
        mem_wdata = 32'h55AA55AA;
        mem_bmask = 4'hF;
        mem_wren  = 1'b1;
        mem_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("s5_wait_ready", {31'b0, mem_ready}, 32'd0);
        end
        @(negedge clk);
        rst_n     = 1'b0;
        mem_valid = 1'b0;
        #1;
        check("s5_rst_ready", {31'b0, mem_ready}, 32'd0);
        check("s5_rst_rdata", mem_rdata, 32'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        seq_m        = 1'b0;
        in_ack       = 1'b0;
        last_rdata_m = '0;
        rd_m = 0;
        wr_m = 0;
        wait_m = 0;
        idle(4);

        // ---- scenario 2: 16-beat read burst ----
        for (int i = 0; i < 16; i++)
            beat(ADDR_W'(18'h00100 + i * 4), 32'h0, 4'h0, 1'b0, "s2", rd);
        idle(2);

        // ---- scenario 3: byte-masked write, then read back ----
        beat(18'h00080, 32'h11223344, 4'b0101, 1'b1, "s3w", rd);
        beat(18'h00080, 32'h0, 4'h0, 1'b0, "s3r", rd);
        check("s3_value", rd, 32'hAA22AA44);
        idle(2);
`ifdef MEM_RESP_STATS_EN
        check("s6_rd_beats",   stat_rd,   32'd17);
        check("s6_wr_beats",   stat_wr,   32'd1);
        check("s6_wait_cycles", stat_wait, 32'd9);
`endif

        // ---- the write dropped by reset never reached memory ----
        beat(18'h000C0, 32'h0, 4'h0, 1'b0, "s5_mem", rd);
        idle(1);

        // ---- randomized beats: mix of bursts, gaps, directions, masks ----
        w = 1'b0;
        a = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) w = ~w;
            if ($urandom_range(0, 2) == 0) a = ADDR_W'($urandom);
            else                           a = prev_addr_m + ADDR_W'(4);
            beat(a, $urandom, 4'($urandom), w, "rand", rd);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit in case the stimulus itself stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
